// File: rtl/nibble_packer_pkg.sv
// Constants shared by the nibble packer and the word-wide datapath.
// The slot helper keeps nibble placement identical in both blocks.
package nibble_packer_pkg;

    localparam int DEFAULT_DIN_W = 4;
    localparam int DEFAULT_RATIO = 4;

    function automatic int slot_index(input bit lsb_first, input int k, input int ratio);
        return lsb_first ? k : (ratio - 1 - k);
    endfunction

endpackage

// File: rtl/nibble_packer.sv
// Packs RATIO input nibbles into one registered output word with a keep mask.
// The accumulator can hold one finished word while the output slot is stalled.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int DIN_W     = DEFAULT_DIN_W,
    parameter int RATIO     = DEFAULT_RATIO,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIN_W-1:0]       din,
    input  logic                   din_valid,
    input  logic                   din_last,
    output logic                   din_ready,
    output logic [DIN_W*RATIO-1:0] dout,
    output logic [RATIO-1:0]       dout_keep,
    output logic                   dout_last,
    output logic                   dout_valid,
    input  logic                   dout_ready
);

    localparam int W     = DIN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO);

    logic [W-1:0]     acc_data_q, acc_data_d;
    logic [RATIO-1:0] acc_keep_q, acc_keep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_last_q, acc_last_d;
    logic             pending_q, pending_d;
    logic [W-1:0]     dout_q, dout_d;
    logic [RATIO-1:0] dout_keep_q, dout_keep_d;
    logic             dout_last_q, dout_last_d;
    logic             dout_valid_q, dout_valid_d;

    logic             out_free;
    logic             accept;
    logic             complete;
    int               slot_idx;
    logic [W-1:0]     merged_data;
    logic [RATIO-1:0] merged_keep;

    assign out_free  = !dout_valid_q || dout_ready;
    assign din_ready = !pending_q || out_free;
    assign accept    = din_valid && din_ready;
    assign complete  = accept && ((cnt_q == CNT_W'(RATIO - 1)) || din_last);

    // A pending word occupies the accumulator, so a new word starts from empty.
    always_comb begin
        slot_idx    = slot_index(LSB_FIRST, int'(cnt_q), RATIO);
        merged_data = pending_q ? '0 : acc_data_q;
        merged_keep = pending_q ? '0 : acc_keep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (i == slot_idx) begin
                merged_data[i*DIN_W +: DIN_W] = din;
                merged_keep[i]                = 1'b1;
            end
        end
    end

    always_comb begin
        acc_data_d   = acc_data_q;
        acc_keep_d   = acc_keep_q;
        acc_last_d   = acc_last_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        dout_d       = dout_q;
        dout_keep_d  = dout_keep_q;
        dout_last_d  = dout_last_q;
        dout_valid_d = dout_valid_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (pending_q && out_free) begin
            dout_d       = acc_data_q;
            dout_keep_d  = acc_keep_q;
            dout_last_d  = acc_last_q;
            dout_valid_d = 1'b1;
            pending_d    = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                cnt_d = '0;
                if (!pending_q && out_free) begin
                    dout_d       = merged_data;
                    dout_keep_d  = merged_keep;
                    dout_last_d  = din_last;
                    dout_valid_d = 1'b1;
                    acc_data_d   = '0;
                    acc_keep_d   = '0;
                    acc_last_d   = 1'b0;
                end else begin
                    acc_data_d = merged_data;
                    acc_keep_d = merged_keep;
                    acc_last_d = din_last;
                    pending_d  = 1'b1;
                end
            end else begin
                acc_data_d = merged_data;
                acc_keep_d = merged_keep;
                acc_last_d = 1'b0;
                cnt_d      = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data_q   <= '0;
            acc_keep_q   <= '0;
            acc_last_q   <= 1'b0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            dout_q       <= '0;
            dout_keep_q  <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            acc_data_q   <= acc_data_d;
            acc_keep_q   <= acc_keep_d;
            acc_last_q   <= acc_last_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            dout_q       <= dout_d;
            dout_keep_q  <= dout_keep_d;
            dout_last_q  <= dout_last_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_keep  = dout_keep_q;
    assign dout_last  = dout_last_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream consumer of the 4-bit valid/ready register stage.
- Accepts a stream of DIN_W-bit nibbles and packs RATIO of them into one wide word on a valid/ready output.
- A din_last marker flushes a partial word early. dout_keep marks which slots in the word are filled.
- Sits between the nibble pipeline and the word-wide datapath.

Parameters:
- DIN_W, 4, width of one input nibble
- RATIO, 4, nibbles per output word (legal range 2..16); output width is DIN_W*RATIO
- LSB_FIRST, 1, 1 = first nibble goes to bits [DIN_W-1:0]; 0 = first nibble goes to the top slot

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- din  input  DIN_W  input nibble
- din_valid  input  1  input nibble valid
- din_last  input  1  qualified by din_valid; this nibble ends the current word
- din_ready  output  1  block can accept a nibble this cycle
- dout  output  DIN_W*RATIO  packed word, registered
- dout_keep  output  RATIO  per-slot filled mask, registered
- dout_last  output  1  word was closed by din_last, registered
- dout_valid  output  1  output word valid, registered
- dout_ready  input  1  downstream accepts the word

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - dout, dout_keep, dout_last, dout_valid = 0.
  - Accumulator data, cnt and keep = 0; pending = 0.
- Reset mid-operation discards any partial word and any pending or output word.
- Internal state:
  - Accumulator: data, keep, cnt (0..RATIO-1), last flag.
  - pending flag: accumulator holds a completed word not yet moved to the output.
- Handshake terms:
  - out_free = !dout_valid || dout_ready.
  - din_ready = !pending || out_free. Combinational, with no dependence on din_valid.
  - accept = din_valid && din_ready. A transfer happens only on accept.
  - Output transfer = dout_valid && dout_ready.
  - While dout_valid=1 and dout_ready=0, dout, dout_keep and dout_last are held stable.
- Nibble placement for the k-th nibble of a word (k = cnt at accept):
  - LSB_FIRST=1: slot k.
  - LSB_FIRST=0: slot RATIO-1-k.
  - The slot's keep bit is set. Unfilled slots are 0 in both data and keep.
- Completion: accept && (cnt==RATIO-1 || din_last). The completing nibble is merged into the word, and dout_last takes din_last.
- Cycle actions (priority as listed; all registered on the same edge):
  1. pending && out_free: the accumulator word moves to the output regs; dout_valid=1; pending clears.
  2. Completion && !pending && out_free: the merged word loads the output regs directly; dout_valid=1.
  3. Completion otherwise: the merged word is held in the accumulator; pending=1.
     - This covers the case where rule 1 fired this cycle; the new word becomes pending.
  4. On completion: cnt returns to 0 and the accumulator keep clears for the next word.
     - The pending word's data and keep are preserved until it moves.
  5. Accept without completion: cnt++ and the nibble is merged.
  6. dout_ready && dout_valid with nothing loading: dout_valid=0. Data regs keep their last value.
- Latency: the completing nibble accepted at edge N gives dout_valid=1 after edge N when the output is free.
- Throughput: sustains 1 nibble/cycle, i.e. one word per RATIO cycles, with dout_ready held high.
- Backpressure:
  - With the output full, the block absorbs one more full word in the accumulator.
  - It then deasserts din_ready. The stall starts the cycle pending=1 && !out_free.
- din_last on the first nibble gives a word with a single keep bit.
- din_last with cnt==RATIO-1 gives a full keep mask and dout_last=1.
- There is no empty-word output: a last marker always accompanies data.
- din is ignored when din_valid=0; din_last is ignored when din_valid=0.

Decomposition:
- Shared package, holding the constants used by both this block and the word datapath:
  - Default nibble width (4).
  - Default ratio (4).
  - A function returning the slot index for a given LSB_FIRST and k.
- No sub-module. The accumulator and the output slot are small enough to stay flat in one module.

Test Plan (defaults DIN_W=4, RATIO=4, LSB_FIRST=1):
- Reset, then nibbles 1,2,3,4 on consecutive cycles with dout_ready=1 -> one cycle after the 4th accept: dout=16'h4321, dout_keep=4'b1111, dout_last=0, dout_valid=1 for exactly 1 cycle; din_ready stays 1 throughout.
- Nibbles A,B with din_last on B -> dout=16'h00BA, dout_keep=4'b0011, dout_last=1.
- dout_ready=0 while streaming 8 nibbles 0..7 -> dout=16'h3210 held; second word completes into pending; din_ready=0 afterwards; raising dout_ready drains 16'h3210 then 16'h7654 with no loss or duplication.
- LSB_FIRST=0, nibbles 1,2,3,4 -> dout=16'h1234; nibble 5 with din_last -> dout=16'h5000, dout_keep=4'b1000.
- Assert rst_n=0 asynchronously after 2 nibbles accepted and with one word in the output -> dout_valid=0 immediately. After release, nibbles 9,8,7,6 -> dout=16'h6789 with no residue from the earlier partial.
- Random din_valid/dout_ready for 10k cycles against a scoreboard model -> every word and keep mask matches, and outputs are stable under backpressure.
